mddr_resp: RTL and testbench

- Synthesizable mobile-DDR device responder: the memory end of the mddr_ctrl pin interface.
- Used for in-FPGA loopback and bring-up of the SOPC DDR controller without the external RAM.
- Decodes mDDR commands, tracks per-bank open rows and the mode register, stores data in internal block RAM, and returns read bursts after CAS latency.
- SDR-equivalent: one data beat per clk_clk cycle; DQS is emulated as a per-beat toggle.

---
 rtl/mddr_resp.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mddr_resp.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mddr_resp.sv
// mddr_resp: mobile-DDR device responder for in-FPGA loopback of the mDDR
// controller. It decodes the command pins, tracks per-bank open rows and the
// mode register, keeps data in an internal RAM and returns read bursts after
// the CAS latency. One data beat per clk_clk cycle; DQS is emulated as a
// per-beat toggle.
//
// Ports:
//   clk_clk            sole clock
//   reset_reset_n      asynchronous active-low reset
//   mddr_a/ba          address / bank address
//   mddr_cke           clock enable (low = NOP)
//   mddr_cs_n/ras_n/cas_n/we_n  command pins, active low
//   mddr_ldm/udm       low/high byte write masks (1 = do not write)
//   mddr_dq_wr         write data from the controller
//   mddr_dq_rd         read data to the controller
//   mddr_dqs_rd        emulated {udqs, ldqs}: 11 on even beats, 00 on odd
//   mddr_rd_oe         high while a read beat is presented
//   err                sticky protocol error flag
//   mode_bl / mode_cl  current burst length / CAS latency
//
// Handshake: there is no back-pressure. A command is taken on every rising
// edge it is presented; read beats are valid exactly while mddr_rd_oe is high.
module mddr_resp #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [12:0] mddr_a,
  input  logic [1:0]  mddr_ba,
  input  logic        mddr_cke,
  input  logic        mddr_cs_n,
  input  logic        mddr_ras_n,
  input  logic        mddr_cas_n,
  input  logic        mddr_we_n,
  input  logic        mddr_ldm,
  input  logic        mddr_udm,
  input  logic [15:0] mddr_dq_wr,
  output logic [15:0] mddr_dq_rd,
  output logic [1:0]  mddr_dqs_rd,
  output logic        mddr_rd_oe,
  output logic        err,
  output logic [3:0]  mode_bl,
  output logic [1:0]  mode_cl
);
  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  // ---------------------------------------------------------------- decode
  logic [3:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;

  always_comb begin
    cmd    = {mddr_cs_n, mddr_ras_n, mddr_cas_n, mddr_we_n};
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    is_ref = 1'b0;
    is_lmr = 1'b0;
    if (mddr_cke) begin
      case (cmd)
        4'b0011: is_act = 1'b1;
        4'b0101: is_rd  = 1'b1;
        4'b0100: is_wr  = 1'b1;
        4'b0010: is_pre = 1'b1;
        4'b0001: is_ref = 1'b1;
        4'b0000: is_lmr = 1'b1;
        default: ;
      endcase
    end
  end

  // Whole address bus is folded here; only some bits are meaningful for a
  // given command and parameter set.
  logic unused_bits;
  assign unused_bits = ^mddr_a;

  // ---------------------------------------------------------------- banks
  logic [3:0]          bank_act;
  logic [ROW_BITS-1:0] bank_row [4];
  logic                bank_open;

  assign bank_open = bank_act[mddr_ba];

  // Only accepted column commands move the burst engines; erroneous ones
  // have no effect at all (including no truncation).
  logic rd_ok, wr_ok, cancel;
  logic act_err, rw_err, ref_err, lmr_err;

  assign rd_ok   = is_rd && bank_open;
  assign wr_ok   = is_wr && bank_open;
  assign cancel  = rd_ok || wr_ok;
  assign act_err = is_act && bank_open;
  assign rw_err  = (is_rd || is_wr) && !bank_open;
  assign ref_err = is_ref && (|bank_act);

  // ---------------------------------------------------------------- mode
  logic [3:0] lmr_bl;
  logic       lmr_cl_ok;
  logic       lmr_hit;

  always_comb begin
    case (mddr_a[2:0])
      3'b001:  lmr_bl = 4'd2;
      3'b010:  lmr_bl = 4'd4;
      3'b011:  lmr_bl = 4'd8;
      default: lmr_bl = 4'd1;
    endcase
    lmr_cl_ok = (mddr_a[6:4] == 3'b010) || (mddr_a[6:4] == 3'b011);
  end

  assign lmr_hit = is_lmr && (mddr_ba == 2'b00);
  assign lmr_err = lmr_hit && !lmr_cl_ok;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bank_act <= 4'b0000;
      mode_bl  <= 4'd4;
      mode_cl  <= 2'd3;
      err      <= 1'b0;
    end else begin
      if (act_err || rw_err || ref_err || lmr_err) err <= 1'b1;
      if (is_act && !bank_open) bank_act[mddr_ba] <= 1'b1;
      if (is_pre) begin
        if (mddr_a[10]) bank_act <= 4'b0000;
        else            bank_act[mddr_ba] <= 1'b0;
      end
      if (lmr_hit) begin
        mode_bl <= lmr_bl;
        if (lmr_cl_ok) mode_cl <= mddr_a[5:4];
      end
    end
  end

  // Row storage needs no reset: it is only consulted while the bank flag is set.
  always_ff @(posedge clk_clk) begin
    if (is_act && !bank_open) bank_row[mddr_ba] <= mddr_a[ROW_BITS-1:0];
  end

  // Sequential burst order wrapping inside the BL-aligned block.
  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] c,
                                                     input logic [3:0] bl,
                                                     input logic [3:0] i);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(bl - 4'd1);
    return (c & ~m) | ((c + COL_BITS'(i)) & m);
  endfunction

  // ---------------------------------------------------------------- write engine
  // Beat i of a write accepted at edge T is committed at edge T+1+i. Row and
  // bank are latched so a precharge mid-burst does not disturb it.
  logic                wr_busy;
  logic [1:0]          wr_ba;
  logic [ROW_BITS-1:0] wr_row;
  logic [COL_BITS-1:0] wr_col;
  logic [3:0]          wr_bl, wr_idx;
  logic [ADDR_BITS-1:0] waddr;

  assign waddr = {wr_ba, wr_row, burst_col(wr_col, wr_bl, wr_idx)};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_busy <= 1'b0;
      wr_ba   <= '0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_bl   <= 4'd1;
      wr_idx  <= '0;
    end else begin
      if (wr_busy) begin
        wr_idx <= wr_idx + 4'd1;
        if (wr_idx == wr_bl - 4'd1) wr_busy <= 1'b0;
      end
      // The beat due on this edge still commits; later beats are abandoned.
      if (cancel) begin
        wr_busy <= wr_ok;
        wr_ba   <= mddr_ba;
        wr_row  <= bank_row[mddr_ba];
        wr_col  <= mddr_a[COL_BITS-1:0];
        wr_bl   <= mode_bl;
        wr_idx  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- read engine
  // rd_t counts cycles since the READ edge. Beat f is fetched in cycle
  // f+CL-2: one edge for the RAM, one for the output register, so it appears
  // at T+CL+f.
  logic                rd_busy;
  logic [1:0]          rd_ba;
  logic [ROW_BITS-1:0] rd_row;
  logic [COL_BITS-1:0] rd_col;
  logic [3:0]          rd_bl;
  logic [1:0]          rd_cl;
  logic [3:0]          rd_t;
  logic [4:0]          t_plus2;
  logic [3:0]          fetch_idx;
  logic                fetch_valid;
  logic [ADDR_BITS-1:0] raddr;

  assign t_plus2     = {1'b0, rd_t} + 5'd2;
  assign fetch_idx   = 4'(t_plus2 - {3'b000, rd_cl});
  assign fetch_valid = rd_busy && (t_plus2 >= {3'b000, rd_cl}) && (fetch_idx < rd_bl);
  assign raddr       = {rd_ba, rd_row, burst_col(rd_col, rd_bl, fetch_idx)};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_busy <= 1'b0;
      rd_ba   <= '0;
      rd_row  <= '0;
      rd_col  <= '0;
      rd_bl   <= 4'd1;
      rd_cl   <= 2'd3;
      rd_t    <= '0;
    end else if (rd_ok) begin
      rd_busy <= 1'b1;
      rd_ba   <= mddr_ba;
      rd_row  <= bank_row[mddr_ba];
      rd_col  <= mddr_a[COL_BITS-1:0];
      rd_bl   <= mode_bl;
      rd_cl   <= mode_cl;
      rd_t    <= '0;
    end else if (wr_ok) begin
      rd_busy <= 1'b0;
    end else if (rd_busy) begin
      rd_t <= rd_t + 4'd1;
      if (fetch_valid && (fetch_idx == rd_bl - 4'd1)) rd_busy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- storage
  logic [15:0] mem [DEPTH];
  logic [15:0] rdata;

  // Write-before-read at the same address is not needed: a read fetch never
  // shares an edge with a write beat of the same location.
  always_ff @(posedge clk_clk) begin
    if (wr_busy) begin
      if (!mddr_ldm) mem[waddr][7:0]  <= mddr_dq_wr[7:0];
      if (!mddr_udm) mem[waddr][15:8] <= mddr_dq_wr[15:8];
    end
    rdata <= mem[raddr];
  end

  // ---------------------------------------------------------------- output pipe
  // Any accepted READ/WRITE flushes beats still in the pipe, so bursts never
  // overlap and a truncated burst stops at the edge of the new command.
  logic s1_valid, s1_even;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_valid    <= 1'b0;
      s1_even     <= 1'b0;
      mddr_rd_oe  <= 1'b0;
      mddr_dq_rd  <= '0;
      mddr_dqs_rd <= 2'b00;
    end else begin
      s1_valid    <= fetch_valid && !cancel;
      s1_even     <= ~fetch_idx[0];
      mddr_rd_oe  <= s1_valid && !cancel;
      mddr_dq_rd  <= (s1_valid && !cancel) ? rdata : 16'h0000;
      mddr_dqs_rd <= (s1_valid && !cancel && s1_even) ? 2'b11 : 2'b00;
    end
  end

endmodule

// File: tb/tb_mddr_resp.sv
`timescale 1ns/1ps
module tb_mddr_resp;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 6;
  localparam int DEPTH    = 1 << (2 + ROW_BITS + COL_BITS);

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  // ---------------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] a;
  logic [1:0]  ba;
  logic        cke, cs_n, ras_n, cas_n, we_n, ldm, udm;
  logic [15:0] dq_wr, dq_rd;
  logic [1:0]  dqs;
  logic        oe, err;
  logic [3:0]  mode_bl;
  logic [1:0]  mode_cl;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mddr_resp #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .mddr_a(a), .mddr_ba(ba), .mddr_cke(cke),
    .mddr_cs_n(cs_n), .mddr_ras_n(ras_n), .mddr_cas_n(cas_n), .mddr_we_n(we_n),
    .mddr_ldm(ldm), .mddr_udm(udm), .mddr_dq_wr(dq_wr),
    .mddr_dq_rd(dq_rd), .mddr_dqs_rd(dqs), .mddr_rd_oe(oe),
    .err(err), .mode_bl(mode_bl), .mode_cl(mode_cl)
  );

  // ---------------------------------------------------------------- reference model
  logic [15:0] m_mem   [DEPTH];
  logic [1:0]  m_known [DEPTH];
  bit          m_act [4];
  int          m_row [4];
  int          m_bl, m_cl;
  bit          m_err;
  int          m_wr_left, m_wr_i, m_wr_ba, m_wr_row, m_wr_col, m_wr_bl;

  // Expected read beats: {cycle[31:0], dqs[1:0], known{hi,lo}[1:0], data[15:0]}
  logic [51:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;

  function automatic int addr_of(int b, int row, int col, int bl, int i);
    int off;
    off = col % bl;
    return b * (1 << (ROW_BITS + COL_BITS)) + row * (1 << COL_BITS)
           + (col - off) + ((off + i) % bl);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
    m_err     = 1'b0;
    m_bl      = 4;
    m_cl      = 3;
    m_wr_left = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called just after a falling edge; the command is taken at the next rising
  // edge (edge index cyc+1). The model is advanced for that edge here.
  task automatic step(input logic [3:0] cmd, input int b, input int addr,
                      input logic [15:0] d = 16'h0000, input logic [1:0] dm = 2'b00,
                      input bit en = 1'b1);
    int e, ad, row, col;
    logic [15:0] rd;
    {cs_n, ras_n, cas_n, we_n} = cmd;
    ba    = 2'(b);
    a     = 13'(addr);
    dq_wr = d;
    ldm   = dm[0];
    udm   = dm[1];
    cke   = en;
    e     = cyc + 1;

    // Write beat due on this edge commits before the command takes effect.
    if (m_wr_left > 0) begin
      ad = addr_of(m_wr_ba, m_wr_row, m_wr_col, m_wr_bl, m_wr_i);
      if (!dm[0]) begin m_mem[ad][7:0]  = d[7:0];  m_known[ad][0] = 1'b1; end
      if (!dm[1]) begin m_mem[ad][15:8] = d[15:8]; m_known[ad][1] = 1'b1; end
      m_wr_i++;
      m_wr_left--;
    end

    if (en && !cmd[3]) begin
      case (cmd)
        C_ACT: if (m_act[b]) m_err = 1'b1;
               else begin m_act[b] = 1'b1; m_row[b] = addr % (1 << ROW_BITS); end
        C_RD, C_WR: begin
          if (!m_act[b]) m_err = 1'b1;
          else begin
            while (exp_q.size() > 0 && int'(exp_q[$][51:20]) >= e) void'(exp_q.pop_back());
            m_wr_left = 0;
            row = m_row[b];
            col = addr % (1 << COL_BITS);
            if (cmd == C_RD) begin
              for (int i = 0; i < m_bl; i++) begin
                ad = addr_of(b, row, col, m_bl, i);
                rd = m_mem[ad];
                exp_q.push_back({32'(e + m_cl + i), (i % 2 == 0) ? 2'b11 : 2'b00,
                                 m_known[ad], rd});
              end
            end else begin
              m_wr_left = m_bl; m_wr_i = 0;
              m_wr_ba = b; m_wr_row = row; m_wr_col = col; m_wr_bl = m_bl;
            end
          end
        end
        C_PRE: if ((addr >> 10) % 2 == 1) for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
               else m_act[b] = 1'b0;
        C_REF: if (m_act[0] || m_act[1] || m_act[2] || m_act[3]) m_err = 1'b1;
        C_LMR: if (b == 0) begin
          case (addr % 8)
            1: m_bl = 2;
            2: m_bl = 4;
            3: m_bl = 8;
            default: m_bl = 1;
          endcase
          case ((addr >> 4) % 8)
            2: m_cl = 2;
            3: m_cl = 3;
            default: m_err = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    @(posedge clk);
    @(negedge clk);
    chk("err", 32'(err), 32'(m_err));
    chk("mode_bl", 32'(mode_bl), 32'(m_bl));
    chk("mode_cl", 32'(mode_cl), 32'(m_cl));
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 0, 0, 16'($urandom));
  endtask

  task automatic do_reset();
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------- scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [51:0] e;
    logic [15:0] mask;
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][51:20]) < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missed_beat: no beat seen, expected %0h at cycle %0d",
                 exp_q[0][15:0], int'(exp_q[0][51:20]));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && int'(exp_q[0][51:20]) == cyc) begin
        e    = exp_q.pop_front();
        mask = {{8{e[17]}}, {8{e[16]}}};
        chk("rd_oe", 32'(oe), 32'd1);
        chk("rd_dqs", 32'(dqs), 32'(e[19:18]));
        chk("rd_data", 32'(dq_rd & mask), 32'(e[15:0] & mask));
      end else begin
        chk("idle_oe", 32'(oe), 32'd0);
        chk("idle_dqs", 32'(dqs), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int r, b, ad;
    logic [1:0] dm;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 2'b00;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    cke = 1'b1; a = '0; ba = '0; ldm = 1'b0; udm = 1'b0; dq_wr = '0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_dqs", 32'(dqs), 32'd0);
    chk("rst_dq", 32'(dq_rd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bl", 32'(mode_bl), 32'd4);
    chk("rst_cl", 32'(mode_cl), 32'd3);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic BL4/CL3 write then read
    step(C_ACT, 1, 5);
    step(C_WR, 1, 'h10);
    step(C_NOP, 0, 0, 16'h1111);
    step(C_NOP, 0, 0, 16'h2222);
    step(C_NOP, 0, 0, 16'h3333);
    step(C_NOP, 0, 0, 16'h4444);
    step(C_RD, 1, 'h10);
    nops(8);

    // BL8/CL2 with wrap order
    step(C_LMR, 0, 'h023);
    chk("lmr_bl8", 32'(mode_bl), 32'd8);
    chk("lmr_cl2", 32'(mode_cl), 32'd2);
    step(C_WR, 1, 'h08);
    for (int i = 0; i < 8; i++) step(C_NOP, 0, 0, 16'(16'h5000 + i));
    step(C_RD, 1, 'h0D);
    nops(10);

    // BL1 masked write
    step(C_LMR, 0, 'h020);
    step(C_WR, 1, 'h20);
    step(C_NOP, 0, 0, 16'hFFFF);
    step(C_WR, 1, 'h20);
    step(C_NOP, 0, 0, 16'hABCD, 2'b01);
    step(C_RD, 1, 'h20);
    nops(4);

    // Final write beat on the same edge as a READ (BL4/CL2)
    step(C_LMR, 0, 'h022);
    step(C_WR, 1, 'h30);
    step(C_NOP, 0, 0, 16'hA001);
    step(C_NOP, 0, 0, 16'hA002);
    step(C_NOP, 0, 0, 16'hA003);
    step(C_RD, 1, 'h30, 16'hA004);
    nops(8);

    // Back-to-back READs: the first burst is replaced
    step(C_RD, 1, 'h10);
    step(C_RD, 1, 'h08);
    nops(8);

    // Protocol errors are sticky
    step(C_RD, 2, 0);
    chk("err_closed_bank", 32'(err), 32'd1);
    step(C_ACT, 1, 7);
    nops(3);
    chk("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-burst
    step(C_LMR, 0, 'h023);
    step(C_RD, 1, 'h08);
    nops(4);
    chk("pre_reset_oe", 32'(oe), 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_oe", 32'(oe), 32'd0);
    chk("async_dqs", 32'(dqs), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_bl", 32'(mode_bl), 32'd4);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    step(C_RD, 1, 'h10);
    chk("err_after_reset", 32'(err), 32'd1);
    nops(6);

    // Randomized traffic in segments, each starting from reset
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int k = 0; k < 4; k++) step(C_ACT, k, $urandom_range(0, 8191));
      for (int n = 0; n < 200; n++) begin
        r  = $urandom_range(0, 99);
        b  = $urandom_range(0, 3);
        dm = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        if (r < 8)       ad = $urandom_range(0, 8191);
        else if (r < 58) ad = $urandom_range(0, 8191);
        else if (r < 62) ad = $urandom_range(0, 8191);
        else if (r < 63) ad = 0;
        else if (r < 70) begin
          ad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(2, 3);
          ad = ad * 16 + $urandom_range(0, 7);
          if ($urandom_range(0, 3) != 0) b = 0;
        end else ad = 0;
        step(r < 8  ? C_ACT : r < 33 ? C_RD : r < 58 ? C_WR : r < 62 ? C_PRE :
             r < 63 ? C_REF : r < 70 ? C_LMR : C_NOP,
             b, ad, 16'($urandom), dm, $urandom_range(0, 31) != 0);
      end
      nops(14);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
